// File: rtl/munoc_apb_slave_timeout_guard.sv
// APB slave-side timeout guard: forwards APB transfers and aborts any access stuck not-ready too long.
// Latency: zero-cycle pass-through; an abort completes upstream one cycle after the last not-ready access cycle.
// Backpressure: peripheral mpready passes to spready; an abort forces spready=1 with spslverr=1 for one cycle.
// Optional macro MUNOC_APB_TIMEOUT_CAPTURE_EN: when defined, the address and direction of the last abort are captured.
module munoc_apb_slave_timeout_guard #(
  parameter int                      BW_PLATFORM_ADDR = 32,
  parameter int                      BW_NODE_DATA     = 32,
  parameter int                      BW_TIMEOUT       = 8,
  parameter logic [BW_NODE_DATA-1:0] ERROR_RDATA      = '0
) (
  input  logic                        clk_slave,
  input  logic                        rstnn_slave,
  input  logic [BW_PLATFORM_ADDR-1:0] spaddr,
  input  logic                        spwrite,
  input  logic                        spsel,
  input  logic                        spenable,
  input  logic [BW_NODE_DATA-1:0]     spwdata,
  output logic [BW_NODE_DATA-1:0]     sprdata,
  output logic                        spready,
  output logic                        spslverr,
  output logic [BW_PLATFORM_ADDR-1:0] mpaddr,
  output logic                        mpwrite,
  output logic                        mpsel,
  output logic                        mpenable,
  output logic [BW_NODE_DATA-1:0]     mpwdata,
  input  logic [BW_NODE_DATA-1:0]     mprdata,
  input  logic                        mpready,
  input  logic                        mpslverr,
  input  logic [BW_TIMEOUT-1:0]       timeout_limit,
  output logic                        timeout_pulse,
  output logic [7:0]                  timeout_count,
  output logic [BW_PLATFORM_ADDR-1:0] timeout_addr,
  output logic                        timeout_write
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    ABORT = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [BW_TIMEOUT-1:0] cnt_q, cnt_d;
  logic [7:0]            timeout_count_q, timeout_count_d;
  logic                  access;
  logic                  limit_on;
  logic                  abort_entry;

  assign access      = spsel & spenable;
  assign limit_on    = (timeout_limit != '0);
  assign abort_entry = (state_d == ABORT) && (state_q != ABORT);

  // Next-state: count not-ready access cycles; completion, a dropped access or a zero limit returns to IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (access && !mpready && limit_on) begin
          cnt_d   = BW_TIMEOUT'(1);
          state_d = (timeout_limit == BW_TIMEOUT'(1)) ? ABORT : WAIT;
        end
      end
      WAIT: begin
        if (!access || !limit_on || mpready) begin
          // mpready is checked before the limit so a last-moment completion is never aborted
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == timeout_limit - BW_TIMEOUT'(1)) begin
          state_d = ABORT;
        end else begin
          cnt_d = cnt_q + BW_TIMEOUT'(1);
        end
      end
      ABORT: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output mux: transparent outside ABORT; ABORT hides the peripheral and returns an error upstream.
  always_comb begin
    mpaddr        = spaddr;
    mpwrite       = spwrite;
    mpwdata       = spwdata;
    mpsel         = spsel;
    mpenable      = spenable;
    sprdata       = mprdata;
    spready       = mpready;
    spslverr      = mpslverr;
    timeout_pulse = 1'b0;
    if (state_q == ABORT) begin
      mpsel         = 1'b0;
      mpenable      = 1'b0;
      sprdata       = ERROR_RDATA;
      spready       = 1'b1;
      spslverr      = 1'b1;
      timeout_pulse = 1'b1;
    end
  end

  // Saturating abort counter, bumped once per abort entry.
  always_comb begin
    timeout_count_d = timeout_count_q;
    if (abort_entry && (timeout_count_q != 8'hFF)) begin
      timeout_count_d = timeout_count_q + 8'd1;
    end
  end

  // State, wait counter and abort counter registers.
  always_ff @(posedge clk_slave or negedge rstnn_slave) begin
    if (!rstnn_slave) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      timeout_count_q <= '0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      timeout_count_q <= timeout_count_d;
    end
  end

  assign timeout_count = timeout_count_q;

`ifdef MUNOC_APB_TIMEOUT_CAPTURE_EN
  logic [BW_PLATFORM_ADDR-1:0] timeout_addr_q, timeout_addr_d;
  logic                        timeout_write_q, timeout_write_d;

  // Capture the aborted transfer's address and direction; hold until the next abort.
  always_comb begin
    timeout_addr_d  = timeout_addr_q;
    timeout_write_d = timeout_write_q;
    if (abort_entry) begin
      timeout_addr_d  = spaddr;
      timeout_write_d = spwrite;
    end
  end

  // Capture registers.
  always_ff @(posedge clk_slave or negedge rstnn_slave) begin
    if (!rstnn_slave) begin
      timeout_addr_q  <= '0;
      timeout_write_q <= 1'b0;
    end else begin
      timeout_addr_q  <= timeout_addr_d;
      timeout_write_q <= timeout_write_d;
    end
  end

  assign timeout_addr  = timeout_addr_q;
  assign timeout_write = timeout_write_q;
`else
  assign timeout_addr  = '0;
  assign timeout_write = 1'b0;
`endif

endmodule

// File: tb/tb_munoc_apb_slave_timeout_guard.sv
// Directed bench for the APB timeout guard with a response scoreboard.
// Drives inputs #1 after posedge, samples on negedge.
// Peripheral readiness is scripted per transfer; expected responses are queued before each transfer.
module tb_munoc_apb_slave_timeout_guard;

  localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

  logic        clk_slave;
  logic        rstnn_slave;
  logic [31:0] spaddr, spwdata, sprdata, mpaddr, mpwdata, mprdata, timeout_addr;
  logic        spwrite, spsel, spenable, spready, spslverr;
  logic        mpwrite, mpsel, mpenable, mpready, mpslverr;
  logic [7:0]  timeout_limit;
  logic        timeout_pulse, timeout_write;
  logic [7:0]  timeout_count;

  munoc_apb_slave_timeout_guard #(
    .BW_PLATFORM_ADDR(32),
    .BW_NODE_DATA    (32),
    .BW_TIMEOUT      (8),
    .ERROR_RDATA     (ERR_DATA)
  ) dut (
    .clk_slave    (clk_slave),
    .rstnn_slave  (rstnn_slave),
    .spaddr       (spaddr),
    .spwrite      (spwrite),
    .spsel        (spsel),
    .spenable     (spenable),
    .spwdata      (spwdata),
    .sprdata      (sprdata),
    .spready      (spready),
    .spslverr     (spslverr),
    .mpaddr       (mpaddr),
    .mpwrite      (mpwrite),
    .mpsel        (mpsel),
    .mpenable     (mpenable),
    .mpwdata      (mpwdata),
    .mprdata      (mprdata),
    .mpready      (mpready),
    .mpslverr     (mpslverr),
    .timeout_limit(timeout_limit),
    .timeout_pulse(timeout_pulse),
    .timeout_count(timeout_count),
    .timeout_addr (timeout_addr),
    .timeout_write(timeout_write)
  );

  initial clk_slave = 1'b0;
  always #5 clk_slave = ~clk_slave;

  typedef struct {
    logic [31:0] rdata;
    logic        slverr;
    int          pulses;
    int          access;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  int          model_count = 0;
  logic [31:0] model_addr = '0;
  logic        model_wr = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_capture(input string tag);
`ifdef MUNOC_APB_TIMEOUT_CAPTURE_EN
    chk({tag, "_taddr"}, timeout_addr, model_addr);
    chk({tag, "_twrite"}, timeout_write, model_wr);
`else
    chk({tag, "_taddr"}, timeout_addr, 64'd0);
    chk({tag, "_twrite"}, timeout_write, 64'd0);
`endif
  endtask

  // One APB transfer; entered and left #1 after a posedge so calls chain back-to-back.
  // ready_at: access cycle where mpready rises (0 = never); drop_at: access cycle where the limit goes to 0.
  task automatic run_xfer(input string tag, input logic [31:0] addr, input logic wr,
                          input logic [31:0] wdata, input int ready_at,
                          input logic [31:0] prdata, input logic pslverr, input int drop_at);
    exp_t        e;
    int          lim;
    int          cyc;
    int          acc;
    int          pulses;
    logic        got;
    logic        aborts;
    logic [31:0] rd;
    logic        se;
    lim    = int'(timeout_limit);
    aborts = (lim != 0) && (ready_at == 0 || ready_at > lim) && (drop_at == 0 || drop_at > lim);
    e.rdata  = aborts ? ERR_DATA : prdata;
    e.slverr = aborts ? 1'b1 : pslverr;
    e.pulses = aborts ? 1 : 0;
    e.access = aborts ? lim : ready_at;
    if (aborts) begin
      if (model_count < 255) model_count++;
      model_addr = addr;
      model_wr   = wr;
    end
    sb_q.push_back(e);

    spaddr = addr; spwrite = wr; spwdata = wdata;
    spsel = 1'b1; spenable = 1'b0;
    mpready = 1'b0; mprdata = prdata; mpslverr = pslverr;
    @(negedge clk_slave);
    chk({tag, "_setup_mpsel"}, mpsel, 64'd1);
    chk({tag, "_setup_mpenable"}, mpenable, 64'd0);
    chk({tag, "_setup_mpaddr"}, mpaddr, addr);
    @(posedge clk_slave); #1;
    spenable = 1'b1;

    cyc = 0; acc = 0; pulses = 0; got = 1'b0; rd = 'x; se = 1'bx;
    while (!got && cyc < 1200) begin
      cyc++;
      if (drop_at != 0 && cyc == drop_at) timeout_limit = 8'd0;
      mpready = (cyc == ready_at);
      @(negedge clk_slave);
      if (mpsel && mpenable) acc++;
      if (timeout_pulse) pulses++;
      if (spready) begin
        got = 1'b1;
        rd  = sprdata;
        se  = spslverr;
      end
      @(posedge clk_slave); #1;
    end
    spsel = 1'b0; spenable = 1'b0; mpready = 1'b0;

    chk({tag, "_resp_seen"}, got, 64'd1);
    e = sb_q.pop_front();
    chk({tag, "_rdata"}, rd, e.rdata);
    chk({tag, "_slverr"}, se, e.slverr);
    chk({tag, "_access_cycles"}, acc, e.access);
    chk({tag, "_pulses"}, pulses, e.pulses);
    chk({tag, "_tcount"}, timeout_count, model_count);
    chk_capture(tag);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    int pv_pulses;
    rstnn_slave = 1'b0;
    spaddr = 32'h0; spwrite = 1'b0; spwdata = 32'h0;
    spsel = 1'b1; spenable = 1'b1;
    mprdata = 32'hA5A5_5A5A; mpready = 1'b0; mpslverr = 1'b0;
    timeout_limit = 8'd4;

    // Reset state with pass-through active
    @(negedge clk_slave);
    chk("rst_mpsel", mpsel, 64'd1);
    chk("rst_mpenable", mpenable, 64'd1);
    chk("rst_sprdata", sprdata, 32'hA5A5_5A5A);
    chk("rst_spready", spready, 64'd0);
    chk("rst_pulse", timeout_pulse, 64'd0);
    chk("rst_tcount", timeout_count, 64'd0);
    chk_capture("rst");
    repeat (3) @(negedge clk_slave);
    chk("rst_hold_pulse", timeout_pulse, 64'd0);
    @(posedge clk_slave); #1;
    spsel = 1'b0; spenable = 1'b0;
    @(posedge clk_slave); #1;
    rstnn_slave = 1'b1;
    @(posedge clk_slave); #1;

    // Limit 4: stuck read aborts, then ready on the 4th cycle completes normally
    timeout_limit = 8'd4;
    run_xfer("lim4_abort", 32'h0000_1000, 1'b0, 32'h0, 0, 32'h1111_2222, 1'b0, 0);
    run_xfer("lim4_ready4", 32'h0000_1004, 1'b0, 32'h0, 4, 32'h1234_5678, 1'b0, 0);
    // Back-to-back: abort then single-cycle access
    run_xfer("b2b_abort", 32'h0000_2000, 1'b1, 32'hCAFE_0001, 0, 32'h0, 1'b0, 0);
    run_xfer("b2b_fast", 32'h0000_2004, 1'b0, 32'h0, 1, 32'h0BAD_F00D, 1'b0, 0);
    // Ready arriving one cycle too late still aborts; peripheral error passes through
    run_xfer("late_ready", 32'h0000_2008, 1'b0, 32'h0, 5, 32'h5555_AAAA, 1'b0, 0);
    run_xfer("periph_err", 32'h0000_200C, 1'b1, 32'h7777_7777, 2, 32'h0, 1'b1, 0);

    // Limit 1: write aborts after its first access cycle
    timeout_limit = 8'd1;
    run_xfer("lim1_write", 32'h4000_0010, 1'b1, 32'h600D_CAFE, 0, 32'h0, 1'b0, 0);

    // Limit 0: guard disabled, 1000 not-ready cycles then completion
    timeout_limit = 8'd0;
    run_xfer("lim0_long", 32'h0000_3000, 1'b0, 32'h0, 1000, 32'h0000_0ABC, 1'b0, 0);

    // Limit drops to 0 mid-wait: no abort
    timeout_limit = 8'd4;
    run_xfer("lim_drop", 32'h0000_3004, 1'b0, 32'h0, 10, 32'h0000_0DEF, 1'b0, 3);
    timeout_limit = 8'd4;

    // Protocol violation in WAIT: no abort, and the next stuck transfer takes the full limit
    spaddr = 32'h0000_4000; spwrite = 1'b0; spsel = 1'b1; spenable = 1'b0;
    @(posedge clk_slave); #1;
    spenable = 1'b1;
    pv_pulses = 0;
    repeat (2) begin
      @(negedge clk_slave);
      if (timeout_pulse) pv_pulses++;
      @(posedge clk_slave); #1;
    end
    spsel = 1'b0; spenable = 1'b0;
    repeat (4) begin
      @(negedge clk_slave);
      if (timeout_pulse) pv_pulses++;
      @(posedge clk_slave); #1;
    end
    chk("pv_pulses", pv_pulses, 64'd0);
    chk("pv_tcount", timeout_count, model_count);
    run_xfer("pv_next", 32'h0000_4004, 1'b0, 32'h0, 0, 32'h0, 1'b0, 0);

    // 300 consecutive timeouts saturate the counter at 255
    timeout_limit = 8'd2;
    for (int i = 0; i < 300; i++) begin
      run_xfer("sat", 32'h0001_0000 + 32'(i), 1'(i % 2), 32'(i), 0, 32'h0, 1'b0, 0);
    end
    chk("sat_tcount_255", timeout_count, 64'd255);

    // Reset asserted mid-WAIT
    timeout_limit = 8'd8;
    spaddr = 32'h0000_5000; spwrite = 1'b1; spsel = 1'b1; spenable = 1'b0; mpready = 1'b0;
    @(posedge clk_slave); #1;
    spenable = 1'b1;
    repeat (3) @(posedge clk_slave);
    #1;
    rstnn_slave = 1'b0;
    model_count = 0; model_addr = '0; model_wr = 1'b0;
    #1;
    chk("midrst_mpsel", mpsel, 64'd1);
    chk("midrst_mpenable", mpenable, 64'd1);
    chk("midrst_spready", spready, 64'd0);
    chk("midrst_pulse", timeout_pulse, 64'd0);
    chk("midrst_tcount", timeout_count, 64'd0);
    chk_capture("midrst");
    @(posedge clk_slave); #1;
    spsel = 1'b0; spenable = 1'b0;
    @(posedge clk_slave); #1;
    rstnn_slave = 1'b1;
    @(posedge clk_slave); #1;
    run_xfer("post_rst", 32'h0000_6000, 1'b1, 32'h1, 0, 32'h0, 1'b0, 0);

    chk("sb_empty", sb_q.size(), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
